// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a one-deep valid/ready output stage
// and a multiply/divide busy sequencer that stalls dependent HI/LO traffic.
module alu_control_seq #(
  parameter int OP_W          = 6,
  parameter int FUNCT_W       = 6,
  parameter int ALUOP_W       = 5,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] alu_operation,
  output logic               jr_flag,
  output logic               illegal,
  output logic               muldiv_start,
  output logic               busy
);

  // state | meaning
  // IDLE  | muldiv unit free; MULT/MULTU/DIV/DIVU and MFHI/MFLO may issue
  // BUSY  | muldiv unit running; count holds remaining cycles minus one
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] count;

  logic [4:0] dec_op;
  logic       dec_jr;
  logic       dec_illegal;
  logic       dec_muldiv;
  logic       dec_hilo;
  logic       hazard;
  logic       accept;

  always_comb begin
    dec_op      = 5'h0F;
    dec_jr      = 1'b0;
    dec_illegal = 1'b1;
    dec_muldiv  = 1'b0;
    dec_hilo    = 1'b0;
    case (opcode)
      6'h00: begin
        dec_illegal = 1'b0;
        case (funct)
          6'h20: dec_op = 5'h00;
          6'h24: dec_op = 5'h01;
          6'h27: dec_op = 5'h03;
          6'h25: dec_op = 5'h04;
          6'h00: dec_op = 5'h05;
          6'h02: dec_op = 5'h06;
          6'h22: dec_op = 5'h07;
          6'h2A: dec_op = 5'h0D;
          6'h08: begin
            dec_op = 5'h0E;
            dec_jr = 1'b1;
          end
          6'h18: begin
            dec_op     = 5'h10;
            dec_muldiv = 1'b1;
          end
          6'h19: begin
            dec_op     = 5'h11;
            dec_muldiv = 1'b1;
          end
          6'h1A: begin
            dec_op     = 5'h12;
            dec_muldiv = 1'b1;
          end
          6'h1B: begin
            dec_op     = 5'h13;
            dec_muldiv = 1'b1;
          end
          6'h10: begin
            dec_op   = 5'h14;
            dec_hilo = 1'b1;
          end
          6'h12: begin
            dec_op   = 5'h15;
            dec_hilo = 1'b1;
          end
          default: begin
            dec_op      = 5'h0F;
            dec_illegal = 1'b1;
          end
        endcase
      end
      6'h08: begin dec_op = 5'h00; dec_illegal = 1'b0; end
      6'h0C: begin dec_op = 5'h01; dec_illegal = 1'b0; end
      6'h0D: begin dec_op = 5'h04; dec_illegal = 1'b0; end
      6'h04: begin dec_op = 5'h08; dec_illegal = 1'b0; end
      6'h05: begin dec_op = 5'h09; dec_illegal = 1'b0; end
      6'h0F: begin dec_op = 5'h0A; dec_illegal = 1'b0; end
      6'h23: begin dec_op = 5'h0B; dec_illegal = 1'b0; end
      6'h2B: begin dec_op = 5'h0C; dec_illegal = 1'b0; end
      default: begin
        dec_op      = 5'h0F;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Anything touching HI/LO must wait until the sequencer is back in IDLE.
  assign hazard   = busy && (dec_muldiv || dec_hilo);
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      alu_operation <= '0;
      jr_flag       <= 1'b0;
      illegal       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      alu_operation <= ALUOP_W'(dec_op);
      jr_flag       <= dec_jr;
      illegal       <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      busy         <= 1'b0;
      muldiv_start <= 1'b0;
    end else begin
      muldiv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && dec_muldiv) begin
            state        <= BUSY;
            count        <= CNT_LOAD;
            busy         <= 1'b1;
            muldiv_start <= 1'b1;
          end
        end
        BUSY: begin
          if (count == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq with a short muldiv latency of 4 cycles.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] alu_operation;
  logic       jr_flag;
  logic       illegal;
  logic       muldiv_start;
  logic       busy;

  int errors = 0;
  int checks = 0;

  alu_control_seq #(
    .OP_W(6), .FUNCT_W(6), .ALUOP_W(5), .MULDIV_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_operation(alu_operation), .jr_flag(jr_flag),
    .illegal(illegal), .muldiv_start(muldiv_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic [5:0] op, input logic [5:0] fn);
    in_valid = v;
    opcode   = op;
    funct    = fn;
    #1;
  endtask

  logic [5:0] s_op  [5] = '{6'h00, 6'h0D, 6'h23, 6'h00, 6'h3F};
  logic [5:0] s_fn  [5] = '{6'h20, 6'h00, 6'h00, 6'h08, 6'h00};
  logic [4:0] s_alu [5] = '{5'h00, 5'h04, 5'h0B, 5'h0E, 5'h0F};
  logic       s_jr  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       s_ill [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int         nbusy;

  initial begin
    reset = 1'b1; in_valid = 1'b0; opcode = '0; funct = '0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu", alu_operation, 5'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", muldiv_start, 1'b0);

    // async reset mid-cycle while an output is held
    req(1'b1, 6'h00, 6'h24);
    tick();
    chk("pre_async_alu", alu_operation, 5'h01);
    req(1'b0, 6'h00, 6'h00);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_alu", alu_operation, 5'h00);
    tick();
    reset = 1'b0;
    req(1'b1, 6'h00, 6'h20);
    tick();
    chk("first_out_valid", out_valid, 1'b1);
    chk("first_alu", alu_operation, 5'h00);

    // streaming, no backpressure
    for (int i = 0; i < 5; i++) begin
      req(1'b1, s_op[i], s_fn[i]);
      chk($sformatf("stream_in_ready_%0d", i), in_ready, 1'b1);
      tick();
      chk($sformatf("stream_alu_%0d", i), alu_operation, s_alu[i]);
      chk($sformatf("stream_jr_%0d", i), jr_flag, s_jr[i]);
      chk($sformatf("stream_ill_%0d", i), illegal, s_ill[i]);
      chk($sformatf("stream_valid_%0d", i), out_valid, 1'b1);
    end
    req(1'b0, 6'h00, 6'h00);
    tick();
    chk("drain_valid", out_valid, 1'b0);

    // backpressure with SUB held, then consume+accept on one edge
    out_ready = 1'b0;
    req(1'b1, 6'h00, 6'h22);
    tick();
    chk("sub_alu", alu_operation, 5'h07);
    req(1'b1, 6'h00, 6'h24);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
      tick();
      chk($sformatf("bp_alu_%0d", i), alu_operation, 5'h07);
      chk($sformatf("bp_valid_%0d", i), out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    chk("b2b_alu", alu_operation, 5'h01);
    chk("b2b_valid", out_valid, 1'b1);
    req(1'b0, 6'h00, 6'h00);
    tick();
    chk("b2b_drain", out_valid, 1'b0);

    // MULT, dependent MFLO stalls, ADD passes
    req(1'b1, 6'h00, 6'h18);
    tick();
    chk("mult_alu", alu_operation, 5'h10);
    chk("mult_start", muldiv_start, 1'b1);
    chk("mult_busy1", busy, 1'b1);
    req(1'b1, 6'h00, 6'h12);
    chk("mflo_hazard1", in_ready, 1'b0);
    req(1'b1, 6'h00, 6'h20);
    chk("add_in_busy_ready", in_ready, 1'b1);
    tick();
    chk("mult_start_pulse", muldiv_start, 1'b0);
    chk("mult_busy2", busy, 1'b1);
    chk("add_in_busy_alu", alu_operation, 5'h00);
    req(1'b1, 6'h00, 6'h12);
    chk("mflo_hazard2", in_ready, 1'b0);
    tick();
    chk("mult_busy3", busy, 1'b1);
    chk("mflo_stall_valid", out_valid, 1'b0);
    tick();
    chk("mult_busy4", busy, 1'b1);
    chk("mflo_hazard_last", in_ready, 1'b0);
    tick();
    chk("mult_idle", busy, 1'b0);
    chk("mflo_ready_idle", in_ready, 1'b1);
    tick();
    chk("mflo_alu", alu_operation, 5'h15);
    chk("mflo_valid", out_valid, 1'b1);

    // flush while holding output during BUSY
    out_ready = 1'b0;
    req(1'b0, 6'h00, 6'h00);
    tick();
    req(1'b1, 6'h00, 6'h1A);
    out_ready = 1'b1;
    #1;
    tick();
    out_ready = 1'b0;
    chk("div_alu", alu_operation, 5'h12);
    chk("div_busy1", busy, 1'b1);
    req(1'b1, 6'h00, 6'h20);
    flush = 1'b1;
    #1;
    chk("flush_blocks", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    req(1'b0, 6'h00, 6'h00);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_busy2", busy, 1'b1);
    tick();
    chk("flush_busy3", busy, 1'b1);
    tick();
    chk("flush_busy4", busy, 1'b1);
    tick();
    chk("flush_idle", busy, 1'b0);

    // reset in BUSY with count=2, then a DIV restarts the full count
    out_ready = 1'b1;
    req(1'b1, 6'h00, 6'h1B);
    tick();
    chk("divu_alu", alu_operation, 5'h13);
    req(1'b0, 6'h00, 6'h00);
    tick();
    chk("divu_busy2", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy_drop", busy, 1'b0);
    chk("rst_busy_valid", out_valid, 1'b0);
    tick();
    reset = 1'b0;
    req(1'b1, 6'h00, 6'h1A);
    chk("div2_ready", in_ready, 1'b1);
    tick();
    req(1'b0, 6'h00, 6'h00);
    chk("div2_start", muldiv_start, 1'b1);
    chk("div2_alu", alu_operation, 5'h12);
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) nbusy++;
      tick();
    end
    chk("div2_busy_cycles", nbusy, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
